// File: rtl/pdt_weight_mc.sv
// -----------------------------------------------------------------------------
// pdt_weight_mc
//   Multi-channel, multi-candidate predictor weight/product stage.
//   Keeps one signed weight per channel. For each input sample it forms
//   NUM_CAND clipped candidate weights (weight + per-candidate offset),
//   multiplies each by the signed sample difference, and registers the
//   products. DEC_LAT cycles after a sample, an external decision selects one
//   candidate, which is written back into that channel's weight. A recovery
//   port overwrites weights directly.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   dn_en_i/dn_ch_i/dn_i  sample valid, channel, signed sample difference
//   off_i                 NUM_CAND signed offsets, candidate k at [k*D_WIDTH +: D_WIDTH]
//   sel_en_i/sel_idx_i    commit decision valid, chosen candidate index
//   rec_en_i/rec_ch_i/rec_data_i  direct weight overwrite
//   dw_o/dw_en_o/dw_ch_o  registered products, valid pulse, channel
//   wt_o/wt_ch_o/wt_en_o  committed weight, channel, valid pulse
//   sel_err_o             sticky protocol error (cleared by reset only)
// -----------------------------------------------------------------------------
module pdt_weight_mc #(
  parameter int W_WIDTH  = 31,
  parameter int D_WIDTH  = 15,
  parameter int NUM_CAND = 3,
  parameter int NUM_CH   = 4,
  parameter int DEC_LAT  = 3,
  parameter logic signed [W_WIDTH-1:0] W_INIT = '0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int P_WIDTH = W_WIDTH + D_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dn_en_i,
  input  logic [CH_W-1:0]                 dn_ch_i,
  input  logic signed [D_WIDTH-1:0]       dn_i,
  input  logic [NUM_CAND*D_WIDTH-1:0]     off_i,
  input  logic                            sel_en_i,
  input  logic [2:0]                      sel_idx_i,
  input  logic                            rec_en_i,
  input  logic [CH_W-1:0]                 rec_ch_i,
  input  logic signed [W_WIDTH-1:0]       rec_data_i,
  output logic [NUM_CAND*P_WIDTH-1:0]     dw_o,
  output logic                            dw_en_o,
  output logic [CH_W-1:0]                 dw_ch_o,
  output logic signed [W_WIDTH-1:0]       wt_o,
  output logic [CH_W-1:0]                 wt_ch_o,
  output logic                            wt_en_o,
  output logic                            sel_err_o
);

  // Saturating add of a weight and an offset, evaluated one bit wider.
  function automatic logic signed [W_WIDTH-1:0] f_clip(
    input logic signed [W_WIDTH-1:0] a,
    input logic signed [D_WIDTH-1:0] b
  );
    logic signed [W_WIDTH:0] s;
    s = (W_WIDTH+1)'(a) + (W_WIDTH+1)'(b);
    case (s[W_WIDTH -: 2])
      2'b01:   return {1'b0, {(W_WIDTH-1){1'b1}}};
      2'b10:   return {1'b1, {(W_WIDTH-1){1'b0}}};
      default: return s[W_WIDTH-1:0];
    endcase
  endfunction

  // Keeps array indexing in range when NUM_CH == 1 (CH_W is forced to 1).
  function automatic logic [CH_W-1:0] f_idx(input logic [CH_W-1:0] ch);
    return ch & CH_W'(NUM_CH - 1);
  endfunction

  logic signed [W_WIDTH-1:0]       r_wt     [NUM_CH];
  logic                            r_dl_vld [DEC_LAT];
  logic [CH_W-1:0]                 r_dl_ch  [DEC_LAT];
  logic [NUM_CAND*D_WIDTH-1:0]     r_dl_off [DEC_LAT];

  logic                            w_tail_vld;
  logic [CH_W-1:0]                 w_tail_ch;
  logic [NUM_CAND*D_WIDTH-1:0]     w_tail_off;
  logic signed [D_WIDTH-1:0]       w_off_sel;
  logic                            w_idx_ok;
  logic                            w_commit;
  logic                            w_sel_err;
  logic signed [W_WIDTH-1:0]       w_commit_wt;
  logic signed [W_WIDTH-1:0]       w_weff;
  logic [NUM_CAND*P_WIDTH-1:0]     w_prod;

  assign w_tail_vld = r_dl_vld[DEC_LAT-1];
  assign w_tail_ch  = r_dl_ch[DEC_LAT-1];
  assign w_tail_off = r_dl_off[DEC_LAT-1];

  assign w_idx_ok  = ({1'b0, sel_idx_i} < 4'(NUM_CAND));
  assign w_commit  = sel_en_i & w_tail_vld & w_idx_ok;
  assign w_sel_err = sel_en_i & (~w_tail_vld | ~w_idx_ok);

  // Offset mux only decodes legal indices; illegal ones never commit.
  always_comb begin
    w_off_sel = '0;
    for (int unsigned k = 0; k < NUM_CAND; k++) begin
      if (sel_idx_i == 3'(k)) begin
        w_off_sel = w_tail_off[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign w_commit_wt = f_clip(r_wt[f_idx(w_tail_ch)], w_off_sel);

  // Effective weight for the incoming sample: a same-cycle recovery beats a
  // same-cycle commit, which beats the stored value.
  always_comb begin
    w_weff = r_wt[f_idx(dn_ch_i)];
    if (rec_en_i && (rec_ch_i == dn_ch_i)) begin
      w_weff = rec_data_i;
    end else if (w_commit && (w_tail_ch == dn_ch_i)) begin
      w_weff = w_commit_wt;
    end
  end

  // Both factors are sign-extended to the product width, so the truncated
  // result equals the full signed product.
  always_comb begin
    w_prod = '0;
    for (int unsigned k = 0; k < NUM_CAND; k++) begin
      w_prod[k*P_WIDTH +: P_WIDTH] =
        P_WIDTH'(f_clip(w_weff, off_i[k*D_WIDTH +: D_WIDTH])) * P_WIDTH'(dn_i);
    end
  end

  // Weight store. The recovery write is issued last so it overrides a commit
  // to the same channel in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_wt[c] <= W_INIT;
      end
    end else begin
      if (w_commit) begin
        r_wt[f_idx(w_tail_ch)] <= w_commit_wt;
      end
      if (rec_en_i) begin
        r_wt[f_idx(rec_ch_i)] <= rec_data_i;
      end
    end
  end

  // Decision delay line: one entry per cycle, valid only for real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEC_LAT; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_ch[i]  <= '0;
        r_dl_off[i] <= '0;
      end
    end else begin
      r_dl_vld[0] <= dn_en_i;
      r_dl_ch[0]  <= dn_ch_i;
      r_dl_off[0] <= off_i;
      for (int unsigned i = 1; i < DEC_LAT; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_ch[i]  <= r_dl_ch[i-1];
        r_dl_off[i] <= r_dl_off[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw_o      <= '0;
      dw_en_o   <= 1'b0;
      dw_ch_o   <= '0;
      wt_o      <= '0;
      wt_ch_o   <= '0;
      wt_en_o   <= 1'b0;
      sel_err_o <= 1'b0;
    end else begin
      dw_en_o <= dn_en_i;
      if (dn_en_i) begin
        dw_o    <= w_prod;
        dw_ch_o <= dn_ch_i;
      end
      wt_en_o <= w_commit;
      if (w_commit) begin
        wt_o    <= w_commit_wt;
        wt_ch_o <= w_tail_ch;
      end
      if (w_sel_err) begin
        sel_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdt_weight_mc.sv
module tb_pdt_weight_mc;

  localparam int W_WIDTH  = 31;
  localparam int D_WIDTH  = 15;
  localparam int NUM_CAND = 3;
  localparam int NUM_CH   = 4;
  localparam int DEC_LAT  = 3;
  localparam int CH_W     = 2;
  localparam int P_WIDTH  = W_WIDTH + D_WIDTH;
  localparam longint WMAX = 1073741823;
  localparam longint WMIN = -1073741824;

  logic                          clk;
  logic                          rst_n;
  logic                          dn_en_i;
  logic [CH_W-1:0]               dn_ch_i;
  logic signed [D_WIDTH-1:0]     dn_i;
  logic [NUM_CAND*D_WIDTH-1:0]   off_i;
  logic                          sel_en_i;
  logic [2:0]                    sel_idx_i;
  logic                          rec_en_i;
  logic [CH_W-1:0]               rec_ch_i;
  logic signed [W_WIDTH-1:0]     rec_data_i;
  logic [NUM_CAND*P_WIDTH-1:0]   dw_o;
  logic                          dw_en_o;
  logic [CH_W-1:0]               dw_ch_o;
  logic signed [W_WIDTH-1:0]     wt_o;
  logic [CH_W-1:0]               wt_ch_o;
  logic                          wt_en_o;
  logic                          sel_err_o;

  pdt_weight_mc #(
    .W_WIDTH (W_WIDTH),
    .D_WIDTH (D_WIDTH),
    .NUM_CAND(NUM_CAND),
    .NUM_CH  (NUM_CH),
    .DEC_LAT (DEC_LAT),
    .W_INIT  ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dn_en_i   (dn_en_i),
    .dn_ch_i   (dn_ch_i),
    .dn_i      (dn_i),
    .off_i     (off_i),
    .sel_en_i  (sel_en_i),
    .sel_idx_i (sel_idx_i),
    .rec_en_i  (rec_en_i),
    .rec_ch_i  (rec_ch_i),
    .rec_data_i(rec_data_i),
    .dw_o      (dw_o),
    .dw_en_o   (dw_en_o),
    .dw_ch_o   (dw_ch_o),
    .wt_o      (wt_o),
    .wt_ch_o   (wt_ch_o),
    .wt_en_o   (wt_en_o),
    .sel_err_o (sel_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One stimulus cycle plus optional hand-derived expectations.
  typedef struct {
    bit     rec_en;  int rec_ch;  longint rec_data;
    bit     dn_en;   int dn_ch;   int dn;  int o0; int o1; int o2;
    bit     sel_en;  int sel_idx;
    bit     cdw;     longint e0;  longint e1;  longint e2;
    bit     cwt;     bit e_wten;  longint e_wt; int e_wtch;
    bit     ce;      bit e_err;
  } vec_t;

  typedef struct {
    bit dw_en; int dw_ch; longint dw0; longint dw1; longint dw2;
    bit wt_en; longint wt; int wt_ch; bit err;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint m_w  [NUM_CH];
  bit     m_dv [DEC_LAT];
  int     m_dc [DEC_LAT];
  longint m_do [DEC_LAT][NUM_CAND];
  exp_t   m_out;
  exp_t   sb[$];
  vec_t   tbl[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint clip(input longint s);
    if (s > WMAX) return WMAX;
    if (s < WMIN) return WMIN;
    return s;
  endfunction

  function automatic longint dw_at(input int k);
    logic signed [P_WIDTH-1:0] p;
    p = dw_o[k*P_WIDTH +: P_WIDTH];
    return longint'(p);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_w[c] = 0;
    for (int i = 0; i < DEC_LAT; i++) begin
      m_dv[i] = 0;
      m_dc[i] = 0;
      for (int k = 0; k < NUM_CAND; k++) m_do[i][k] = 0;
    end
    m_out = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    sb.delete();
  endtask

  task automatic idle_inputs();
    dn_en_i = 0; dn_ch_i = '0; dn_i = '0; off_i = '0;
    sel_en_i = 0; sel_idx_i = '0;
    rec_en_i = 0; rec_ch_i = '0; rec_data_i = '0;
  endtask

  task automatic cycle(input vec_t v);
    exp_t   e;
    exp_t   got;
    longint offs[NUM_CAND];
    longint nv;
    longint weff;
    bit     bad;
    bit     commit;
    int     tch;

    dn_en_i    = v.dn_en;
    dn_ch_i    = CH_W'(v.dn_ch);
    dn_i       = D_WIDTH'(v.dn);
    off_i      = {D_WIDTH'(v.o2), D_WIDTH'(v.o1), D_WIDTH'(v.o0)};
    sel_en_i   = v.sel_en;
    sel_idx_i  = 3'(v.sel_idx);
    rec_en_i   = v.rec_en;
    rec_ch_i   = CH_W'(v.rec_ch);
    rec_data_i = W_WIDTH'(v.rec_data);
    offs[0] = v.o0; offs[1] = v.o1; offs[2] = v.o2;

    e      = m_out;
    bad    = v.sel_en && (!m_dv[DEC_LAT-1] || v.sel_idx >= NUM_CAND);
    commit = v.sel_en && !bad;
    tch    = m_dc[DEC_LAT-1];
    nv     = 0;
    if (commit) nv = clip(m_w[tch] + m_do[DEC_LAT-1][v.sel_idx]);
    if (v.rec_en && v.rec_ch == v.dn_ch) weff = v.rec_data;
    else if (commit && tch == v.dn_ch)   weff = nv;
    else                                 weff = m_w[v.dn_ch];
    e.dw_en = v.dn_en;
    if (v.dn_en) begin
      e.dw_ch = v.dn_ch;
      e.dw0 = clip(weff + offs[0]) * v.dn;
      e.dw1 = clip(weff + offs[1]) * v.dn;
      e.dw2 = clip(weff + offs[2]) * v.dn;
    end
    e.wt_en = commit;
    if (commit) begin
      e.wt    = nv;
      e.wt_ch = tch;
    end
    e.err = e.err | bad;
    if (commit)   m_w[tch] = nv;
    if (v.rec_en) m_w[v.rec_ch] = v.rec_data;
    for (int i = DEC_LAT - 1; i > 0; i--) begin
      m_dv[i] = m_dv[i-1];
      m_dc[i] = m_dc[i-1];
      for (int k = 0; k < NUM_CAND; k++) m_do[i][k] = m_do[i-1][k];
    end
    m_dv[0] = v.dn_en;
    m_dc[0] = v.dn_ch;
    for (int k = 0; k < NUM_CAND; k++) m_do[0][k] = offs[k];
    m_out = e;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("sb_dw_en",  longint'(dw_en_o),   longint'(got.dw_en));
    chk("sb_dw_ch",  longint'(dw_ch_o),   longint'(got.dw_ch));
    chk("sb_dw0",    dw_at(0),            got.dw0);
    chk("sb_dw1",    dw_at(1),            got.dw1);
    chk("sb_dw2",    dw_at(2),            got.dw2);
    chk("sb_wt_en",  longint'(wt_en_o),   longint'(got.wt_en));
    chk("sb_wt",     longint'(wt_o),      got.wt);
    chk("sb_wt_ch",  longint'(wt_ch_o),   longint'(got.wt_ch));
    chk("sb_err",    longint'(sel_err_o), longint'(got.err));

    if (v.cdw) begin
      chk("vec_dw_en", longint'(dw_en_o), 1);
      chk("vec_dw0", dw_at(0), v.e0);
      chk("vec_dw1", dw_at(1), v.e1);
      chk("vec_dw2", dw_at(2), v.e2);
    end
    if (v.cwt) begin
      chk("vec_wt_en", longint'(wt_en_o), longint'(v.e_wten));
      if (v.e_wten) begin
        chk("vec_wt",    longint'(wt_o),    v.e_wt);
        chk("vec_wt_ch", longint'(wt_ch_o), longint'(v.e_wtch));
      end
    end
    if (v.ce) chk("vec_err", longint'(sel_err_o), longint'(v.e_err));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dw"},     longint'(|dw_o),      0);
    chk({tag, "_dw_en"},  longint'(dw_en_o),    0);
    chk({tag, "_dw_ch"},  longint'(dw_ch_o),    0);
    chk({tag, "_wt"},     longint'(wt_o),       0);
    chk({tag, "_wt_ch"},  longint'(wt_ch_o),    0);
    chk({tag, "_wt_en"},  longint'(wt_en_o),    0);
    chk({tag, "_err"},    longint'(sel_err_o),  0);
  endtask

  function automatic vec_t rnd_vec(input int ch);
    vec_t v;
    logic signed [D_WIDTH-1:0] r15;
    logic signed [W_WIDTH-1:0] r31;
    v = '{0, 0, 0, 1, ch, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    r15 = D_WIDTH'($urandom); v.dn = r15;
    r15 = D_WIDTH'($urandom); v.o0 = r15;
    r15 = D_WIDTH'($urandom); v.o1 = r15;
    r15 = D_WIDTH'($urandom); v.o2 = r15;
    v.sel_en  = m_dv[DEC_LAT-1];
    v.sel_idx = int'($urandom_range(0, NUM_CAND - 1));
    if ($urandom_range(0, 7) == 0) begin
      v.rec_en = 1;
      v.rec_ch = int'($urandom_range(0, NUM_CH - 1));
      r31 = W_WIDTH'($urandom);
      v.rec_data = r31;
    end
    return v;
  endfunction

  function automatic vec_t probe_vec(input int ch);
    return '{0, 0, 0, 1, ch, 1, 0, 3, -3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    //   rec ch  data         dn ch dn  o0 o1 o2   sel idx  cdw e0 e1 e2   cwt en wt ch  ce err
    add('{0, 0, 0,            1, 0, 3,  0, 5, -5,  0, 0,    1, 0, 15, -15, 0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    1, 0, 0, 0,   1, 0});
    add('{1, 1, 1073741823,   0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            1, 1, -2, 0, 5, -5,  0, 0,    1, -2147483646, -2147483646, -2147483636,
                                                                           0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   1, 2,    0, 0, 0, 0,    1, 1, 1073741818, 1, 1, 0});
    add('{1, 2, 10,           0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            1, 2, 0,  0, 4, 0,   0, 0,    1, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            1, 2, 1,  0, 0, 0,   1, 1,    1, 14, 14, 14, 1, 1, 14, 2,  1, 0});
    add('{0, 0, 0,            1, 2, 1,  0, 0, 0,   0, 0,    1, 14, 14, 14, 0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            1, 3, 1,  7, 7, 7,   0, 0,    1, 7, 7, 7,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 0});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   1, 3,    0, 0, 0, 0,    1, 0, 0, 0,   1, 1});
    add('{0, 0, 0,            1, 3, 1,  0, 0, 0,   0, 0,    1, 0, 0, 0,    0, 0, 0, 0,   1, 1});
    add('{0, 0, 0,            1, 3, 1,  0, 100, 0, 0, 0,    1, 0, 100, 0,  0, 0, 0, 0,   1, 1});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 1});
    add('{0, 0, 0,            0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 1});
    add('{1, 3, 500,          0, 0, 0,  0, 0, 0,   1, 1,    0, 0, 0, 0,    1, 1, 100, 3, 1, 1});
    add('{0, 0, 0,            1, 3, 1,  0, 0, 0,   0, 0,    1, 500, 500, 500, 0, 0, 0, 0, 1, 1});
    add('{1, 0, -1073741824,  0, 0, 0,  0, 0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 0, 0,   1, 1});
    add('{0, 0, 0,            1, 0, 1,  0, -5, 5,  0, 0,    1, -1073741824, -1073741824, -1073741819,
                                                                           0, 0, 0, 0,   1, 1});

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i]);

    // Round-robin stream with a commit on every valid tail
    for (int i = 0; i < 64; i++) cycle(rnd_vec(i % NUM_CH));
    for (int c = 0; c < NUM_CH; c++) cycle(probe_vec(c));

    // Mid-stream reset with samples still pending in the delay line
    for (int i = 0; i < 10; i++) cycle(rnd_vec(i % NUM_CH));
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    model_reset();
    #3;
    rst_n = 1'b1;

    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    cycle(v);
    for (int c = 0; c < NUM_CH; c++) begin
      v = probe_vec(c);
      v.cdw = 1; v.e0 = 0; v.e1 = 3; v.e2 = -3;
      cycle(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pdt_weight_mc.md
Name: pdt_weight_mc

Overview:
- Multi-channel, multi-candidate successor of the predictor weight/product stage.
- Holds one signed weight per channel in an internal register array.
- Per input sample: forms NUM_CAND clipped candidate weights (weight + per-candidate offset), multiplies each by the signed sample difference, and registers the products.
- A later, fixed-latency decision commits one candidate back into that channel's weight; a recovery port overwrites weights directly.

Parameters:
- W_WIDTH, 31, weight width (signed two's complement).
- D_WIDTH, 15, sample difference / offset width (signed).
- NUM_CAND, 3, candidate count, 2..8.
- NUM_CH, 4, weight channels, power of two, 1..16; CH_W = max(1, clog2(NUM_CH)).
- DEC_LAT, 3, cycles from dn_en_i to the matching sel_en_i, 1..8.
- W_INIT, 0, reset value of every weight.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dn_en_i  in  1  sample valid
- dn_ch_i  in  CH_W  sample channel
- dn_i  in  D_WIDTH  signed sample difference
- off_i  in  NUM_CAND*D_WIDTH  signed candidate offsets; candidate k at [k*D_WIDTH +: D_WIDTH]
- sel_en_i  in  1  commit decision valid
- sel_idx_i  in  3  chosen candidate index
- rec_en_i  in  1  recovery write
- rec_ch_i  in  CH_W  recovery channel
- rec_data_i  in  W_WIDTH  recovery weight
- dw_o  out  NUM_CAND*(D_WIDTH+W_WIDTH)  signed products; candidate k at [k*(D_WIDTH+W_WIDTH) +: ...]
- dw_en_o  out  1  products valid
- dw_ch_o  out  CH_W  products channel
- wt_o  out  W_WIDTH  committed weight
- wt_ch_o  out  CH_W  committed channel
- wt_en_o  out  1  commit valid
- sel_err_o  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, rst_n low):
  - all weights = W_INIT; delay line cleared.
  - dw_o, dw_ch_o, wt_o, wt_ch_o = 0; dw_en_o, wt_en_o, sel_err_o = 0.
- Clip: sum computed at W_WIDTH+1 bits (both operands sign-extended). If the top two bits are 01, saturate to 2^(W_WIDTH-1)-1; if 10, saturate to -2^(W_WIDTH-1); otherwise drop the redundant sign bit.
- Product path, latency 1:
  - On dn_en_i, cand_k = clip(w_eff + off_k).
  - dw_k = cand_k * dn_i as a full signed (W_WIDTH+D_WIDTH)-bit product, registered.
  - Next cycle: dw_en_o = 1, dw_ch_o = dn_ch_i. dw_o holds when dw_en_o = 0.
- w_eff bypass order, highest priority first:
  - rec_en_i with rec_ch_i == dn_ch_i: w_eff = rec_data_i.
  - Commit in the same cycle to dn_ch_i: w_eff = the commit result.
  - Otherwise: stored weight.
- Delay line: DEC_LAT-deep shift register of {valid, ch, off_i} loaded on every cycle with dn_en_i; valid = 0 when dn_en_i = 0.
- Commit:
  - sel_en_i is valid only when the delay-line tail is valid.
  - new = clip(w[tail.ch] + tail.off[sel_idx_i]), written to w[tail.ch].
  - Next cycle: wt_o = new, wt_ch_o = tail.ch, wt_en_o = 1 pulse.
- Recovery:
  - rec_en_i writes w[rec_ch_i] = rec_data_i at once, with no output pulse.
  - Recovery to the same channel as a commit in the same cycle wins; the commit still pulses wt_en_o with its computed value, but the stored weight is rec_data_i.
- Errors: sel_err_o sets and stays set until reset on either condition:
  - sel_en_i with tail invalid: commit ignored, no wt_en_o.
  - sel_idx_i >= NUM_CAND: commit ignored, no wt_en_o.
- Back-to-back: dn_en_i is allowed every cycle. Tail valid without sel_en_i is a skipped update: weight unchanged, no error.
- Reset mid-operation clears the pending delay line; sel_en_i arriving afterward for pre-reset samples flags sel_err_o.

Test Plan (defaults unless stated):
1. Reset, then dn_en_i ch0, dn_i = 3, offsets {0, 5, -5} -> one cycle later dw = {0, 15, -15}, dw_en_o = 1, dw_ch_o = 0.
2. rec ch1 = 2^30-1, then dn ch1, dn_i = -2, offsets {0, 5, -5}:
   - Required: cand1 saturates to 2^30-1, dw1 = -2^31+2; dw2 = -2*(2^30-6).
   - Then sel_idx = 2 at DEC_LAT -> wt_o = 2^30-6, wt_ch_o = 1.
3. Commit on ch2 (w = 10, selected off = 4) in the same cycle as dn_en_i ch2, dn_i = 1, off0 = 0 -> dw0 = 14 (bypass); stored w2 = 14.
4. sel_en_i with no sample DEC_LAT cycles earlier -> sel_err_o = 1 and remains 1; no wt_en_o; weights unchanged.
5. sel_idx_i = 3 with NUM_CAND = 3 -> sel_err_o = 1, weight held; separately, rec_en_i and commit on the same channel, same cycle -> stored = rec_data_i, wt_en_o still pulses.
6. Continuous dn_en_i on ch0..3 round-robin with commits on every tail -> each channel's weight matches the reference model after 64 samples; assert rst_n mid-stream -> all weights = W_INIT and outputs 0.
